// File: rtl/program_counter_if.sv
// Fetch-side bus of the program counter: command inputs, the fetch handshake and stack status.
// The return-stack signals exist in every build and are tied off when PC_RETURN_STACK_EN is undefined.
interface program_counter_if #(
   parameter int WIDTH = 16
);
   // Handshake: fetch_valid marks out as a live fetch address. A fetch is accepted on
   // any rising clock edge where fetch_valid and fetch_ready are both high. Only then are
   // load/inc/call/ret acted on. clear does not depend on the handshake.
   logic [WIDTH-1:0] in;
   logic             load;
   logic             inc;
   logic             clear;
   logic             fetch_ready;
   logic             call;
   logic             ret;
   logic             fetch_valid;
   logic [WIDTH-1:0] out;
   logic             stack_full;
   logic             stack_empty;
   logic             stack_err;

   modport master (
      input  in, load, inc, clear, fetch_ready, call, ret,
      output fetch_valid, out, stack_full, stack_empty, stack_err
   );

   modport slave (
      output in, load, inc, clear, fetch_ready, call, ret,
      input  fetch_valid, out, stack_full, stack_empty, stack_err
   );
endinterface

// File: rtl/program_counter.sv
// Fetch-stage program counter with clear/ret/call/load/inc priority, applied on accepted fetches.
// Define PC_RETURN_STACK_EN to build the circular return stack used by call and ret.
module program_counter #(
   parameter int               WIDTH        = 16,
   parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
   parameter int               STACK_DEPTH  = 4
) (
   input  logic              clock,
   input  logic              reset_n,
   program_counter_if.master bus,
   output logic              o_dbg_state  // 0 = BOOT, 1 = ISSUE
);
   typedef enum logic {ST_BOOT = 1'b0, ST_ISSUE = 1'b1} state_e;

   state_e           r_state;
   state_e           w_state_next;
   logic [WIDTH-1:0] r_pc;
   logic [WIDTH-1:0] w_pc_next;
   logic             w_accept;

   always_comb begin
      w_state_next = r_state;
      if (r_state == ST_BOOT) w_state_next = ST_ISSUE;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) r_state <= ST_BOOT;
      else          r_state <= w_state_next;
   end

   assign bus.fetch_valid = (r_state == ST_ISSUE);
   assign w_accept        = bus.fetch_valid & bus.fetch_ready;
   assign o_dbg_state     = r_state;

`ifdef PC_RETURN_STACK_EN
   localparam int PW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
   localparam int CW = $clog2(STACK_DEPTH + 1);

   // r_wr is the next write slot; once full it points at the oldest entry,
   // so a push while full overwrites exactly the entry that must be dropped.
   logic [WIDTH-1:0] r_stack [STACK_DEPTH];
   logic [PW-1:0]    r_wr;
   logic [PW-1:0]    w_wr_inc;
   logic [PW-1:0]    w_wr_dec;
   logic [CW-1:0]    r_count;
   logic             r_err;
   logic             w_full;
   logic             w_empty;
   logic             w_push;
   logic             w_pop;
   logic             w_err;

   assign w_wr_inc = (r_wr == PW'(STACK_DEPTH - 1)) ? '0 : r_wr + 1'b1;
   assign w_wr_dec = (r_wr == '0) ? PW'(STACK_DEPTH - 1) : r_wr - 1'b1;
   assign w_full   = (r_count == CW'(STACK_DEPTH));
   assign w_empty  = (r_count == '0);
`endif

   always_comb begin
      w_pc_next = r_pc;
`ifdef PC_RETURN_STACK_EN
      w_push    = 1'b0;
      w_pop     = 1'b0;
      w_err     = 1'b0;
`endif
      if (bus.clear) begin
         w_pc_next = RESET_VECTOR;
      end else if (w_accept) begin
`ifdef PC_RETURN_STACK_EN
         if (bus.ret) begin
            if (w_empty) begin
               w_pc_next = r_pc + 1'b1;
               w_err     = 1'b1;
            end else begin
               w_pc_next = r_stack[w_wr_dec];
               w_pop     = 1'b1;
            end
         end else if (bus.call) begin
            w_pc_next = bus.in;
            w_push    = 1'b1;
            w_err     = w_full;
         end else
`endif
         if (bus.load) begin
            w_pc_next = bus.in;
         end else if (bus.inc) begin
            w_pc_next = r_pc + 1'b1;
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) r_pc <= RESET_VECTOR;
      else          r_pc <= w_pc_next;
   end

   assign bus.out = r_pc;

`ifdef PC_RETURN_STACK_EN
   always_ff @(posedge clock) begin
      if (w_push) r_stack[r_wr] <= r_pc + 1'b1;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_wr    <= '0;
         r_count <= '0;
         r_err   <= 1'b0;
      end else begin
         r_err <= w_err;
         if (w_push) begin
            r_wr <= w_wr_inc;
            if (!w_full) r_count <= r_count + 1'b1;
         end else if (w_pop) begin
            r_wr    <= w_wr_dec;
            r_count <= r_count - 1'b1;
         end
      end
   end

   assign bus.stack_full  = w_full;
   assign bus.stack_empty = w_empty;
   assign bus.stack_err   = r_err;
`else
   logic w_unused;
   assign w_unused        = &{1'b0, bus.call, bus.ret, (STACK_DEPTH > 0)};
   assign bus.stack_full  = 1'b0;
   assign bus.stack_empty = 1'b1;
   assign bus.stack_err   = 1'b0;
`endif
endmodule

// File: tb/tb_program_counter.sv
// Bench for program_counter: reset, vector table, return-stack sequences and random traffic
// compared against a queue-based reference model.
module tb_program_counter;
  localparam int          W     = 16;
  localparam logic [15:0] RV    = 16'h0000;
  localparam int          DEPTH = 4;
`ifdef PC_RETURN_STACK_EN
  localparam bit STACK_EN = 1'b1;
`else
  localparam bit STACK_EN = 1'b0;
`endif

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  logic dbg_state;

  program_counter_if #(.WIDTH(W)) bus ();

  program_counter #(.WIDTH(W), .RESET_VECTOR(RV), .STACK_DEPTH(DEPTH)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clock = ~clock;

  // reference model state
  logic [15:0] m_pc;
  bit          m_valid;
  bit          m_err;
  logic [15:0] m_stack[$];
  logic [W-1:0] exp_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc    = RV;
    m_valid = 1'b0;
    m_err   = 1'b0;
    m_stack.delete();
  endtask

  task automatic model_edge(input logic rdy, clr, ld, ic, cl, rt, input logic [15:0] d);
    bit acc;
    acc   = m_valid && rdy;
    m_err = 1'b0;
    if (clr) begin
      m_pc = RV;
    end else if (acc) begin
      if (STACK_EN && rt) begin
        if (m_stack.size() == 0) begin
          m_pc  = m_pc + 16'd1;
          m_err = 1'b1;
        end else begin
          m_pc = m_stack.pop_back();
        end
      end else if (STACK_EN && cl) begin
        if (m_stack.size() == DEPTH) begin
          void'(m_stack.pop_front());
          m_err = 1'b1;
        end
        m_stack.push_back(m_pc + 16'd1);
        m_pc = d;
      end else if (ld) begin
        m_pc = d;
      end else if (ic) begin
        m_pc = m_pc + 16'd1;
      end
    end
    m_valid = 1'b1;
  endtask

  // driver: apply inputs, advance one edge, compare against the model
  task automatic step(input logic rdy, clr, ld, ic, cl, rt, input logic [15:0] d);
    logic [W-1:0] e_pc;
    bus.fetch_ready = rdy;
    bus.clear       = clr;
    bus.load        = ld;
    bus.inc         = ic;
    bus.call        = cl;
    bus.ret         = rt;
    bus.in          = d;
    model_edge(rdy, clr, ld, ic, cl, rt, d);
    exp_q.push_back(m_pc);
    @(posedge clock);
    #1;
    e_pc = exp_q.pop_front();
    check16("pc", bus.out, e_pc);
    check1("fetch_valid", bus.fetch_valid, m_valid);
    check1("dbg_state", dbg_state, m_valid);
    check1("stack_full", bus.stack_full, m_stack.size() == DEPTH);
    check1("stack_empty", bus.stack_empty, m_stack.size() == 0);
    check1("stack_err", bus.stack_err, m_err);
  endtask

  typedef struct {
    logic        rdy, clr, ld, ic;
    logic [15:0] din;
    logic [15:0] exp_pc;
    logic        exp_valid;
  } vec_t;

  vec_t tbl[14];

  initial begin
    bus.fetch_ready = 1'b0;
    bus.clear       = 1'b0;
    bus.load        = 1'b0;
    bus.inc         = 1'b0;
    bus.call        = 1'b0;
    bus.ret         = 1'b0;
    bus.in          = '0;
    model_reset();

    //                rdy  clr  ld   ic   din        exp_pc    valid
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b1}; // BOOT edge: no accept
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0001, 1'b1};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0002, 1'b1};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0003, 1'b1};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0003, 1'b1}; // stalled inc holds
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 1'b1, 16'h00A5, 16'h00A5, 1'b1}; // load beats inc
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1};
    tbl[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h0040, 16'h0040, 1'b1};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1}; // clear while stalled
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h0040, 16'h0040, 1'b1};
    tbl[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 16'h1234, 16'h0000, 1'b1}; // clear beats load
    tbl[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 16'hFFFF, 16'hFFFF, 1'b1};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b1}; // wrap
    tbl[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h5555, 16'h0000, 1'b1}; // no command holds

    repeat (2) @(negedge clock);
    check16("reset_pc", bus.out, RV);
    check1("reset_valid", bus.fetch_valid, 1'b0);
    check1("reset_empty", bus.stack_empty, 1'b1);
    check1("reset_full", bus.stack_full, 1'b0);
    check1("reset_err", bus.stack_err, 1'b0);
    reset_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      step(tbl[i].rdy, tbl[i].clr, tbl[i].ld, tbl[i].ic, 1'b0, 1'b0, tbl[i].din);
      check16("tbl_pc", bus.out, tbl[i].exp_pc);
      check1("tbl_valid", bus.fetch_valid, tbl[i].exp_valid);
    end

    // asynchronous reset in the middle of a stalled fetch
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0123);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check16("async_reset_pc", bus.out, 16'h0000);
    check1("async_reset_valid", bus.fetch_valid, 1'b0);
    @(negedge clock);
    reset_n = 1'b1;
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
    check1("valid_after_release", bus.fetch_valid, 1'b1);
    check16("pc_after_release", bus.out, 16'h0000);

`ifdef PC_RETURN_STACK_EN
    // call / ret / ret-underflow
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0010);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0200);
    check16("call_pc", bus.out, 16'h0200);
    check1("call_not_empty", bus.stack_empty, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
    check16("ret_pc", bus.out, 16'h0011);
    check1("ret_empty", bus.stack_empty, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
    check16("underflow_pc", bus.out, 16'h0012);
    check1("underflow_err", bus.stack_err, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    check1("err_one_cycle", bus.stack_err, 1'b0);

    // overflow: five calls into four entries, then unwind
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0100);
    for (int k = 0; k < 5; k++) begin
      logic [15:0] tgt;
      tgt = 16'h1000 * 16'(k + 1);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, tgt);
      check16("call_chain_pc", bus.out, tgt);
      check1("call_chain_err", bus.stack_err, k == 4);
    end
    check1("overflow_full", bus.stack_full, 1'b1);
    for (int k = 0; k < 4; k++) begin
      logic [15:0] ra;
      ra = 16'h4001 - 16'h1000 * 16'(k);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
      check16("lifo_pc", bus.out, ra);
    end
    check1("unwound_empty", bus.stack_empty, 1'b1);
`else
    // without the stack, call and ret have no effect
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0010);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0200);
    check16("call_ignored", bus.out, 16'h0010);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
    check16("ret_ignored", bus.out, 16'h0010);
    check1("ret_no_err", bus.stack_err, 1'b0);
`endif

    // random traffic
    for (int n = 0; n < 500; n++) begin
      logic [15:0] d;
      d = ($urandom_range(0, 7) == 0) ? 16'hFFFE + 16'($urandom_range(0, 1)) : 16'($urandom);
      step($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0,
           1'($urandom_range(0, 1)), $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0, d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
